// File: rtl/fifo_flags_pkg.sv
// Shared constants for the flagged FIFO: default geometry and read-mode encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_flags_pkg;

  localparam int FIFO_WORD_BITS = 8;
  localparam int FIFO_ADDR_BITS = 4;

  // Read-mode encodings for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows raddr_i combinationally.
// Backpressure: none; the owning FIFO gates we_i.
//
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
// Contents are deliberately not reset.
module fifo_ram
  import fifo_flags_pkg::*;
#(
  parameter int WORD_BITS = FIFO_WORD_BITS,
  parameter int ADDR_BITS = FIFO_ADDR_BITS
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WORD_BITS-1:0] rdata_o
);

  logic [WORD_BITS-1:0] mem_q [fifo_depth(ADDR_BITS)];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds, sticky errors, flush, FWFT option.
// Latency: flags/count one cycle after the accepting edge; read data 1 cycle (STD) or head-visible (FWFT).
// Backpressure: writes refused while full, reads refused while empty; refused requests set sticky errors.
//
// Ports: clk_i, reset_i (async, active-high); write_i/wdata_i push; read_i pop (ack in FWFT);
// flush_i empties synchronously; clear_err_i clears overflow_o/underflow_o;
// rdata_o/rvalid_o read side; empty_o/full_o/almost_empty_o/almost_full_o/count_o status.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int WORD_BITS     = FIFO_WORD_BITS,
  parameter int ADDR_BITS     = FIFO_ADDR_BITS,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_BITS) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 write_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  input  logic                 read_i,
  input  logic                 flush_i,
  input  logic                 clear_err_i,
  output logic [WORD_BITS-1:0] rdata_o,
  output logic                 rvalid_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 almost_empty_o,
  output logic                 almost_full_o,
  output logic [ADDR_BITS:0]   count_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int                DEPTH    = fifo_depth(ADDR_BITS);
  localparam logic [ADDR_BITS:0] DEPTH_C  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_C  = (ADDR_BITS+1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] AEMPTY_C = (ADDR_BITS+1)'(AEMPTY_THRESH);

  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [ADDR_BITS-1:0] rptr_q, rptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [WORD_BITS-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic                 empty, full;
  logic                 wr_acc, rd_acc;
  logic [WORD_BITS-1:0] ram_rdata;

  fifo_ram #(
    .WORD_BITS (WORD_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wdata_i),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_C);

    // Acceptance uses only the current flags, so full+read+write pops but
    // refuses the push, and empty+read+write pushes but refuses the pop.
    // A flush cancels both without flagging an error.
    wr_acc = write_i && !full  && !flush_i;
    rd_acc = read_i  && !empty && !flush_i;

    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;

    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ADDR_BITS'(1);
      if (rd_acc) begin
        rptr_d  = rptr_q + ADDR_BITS'(1);
        rdata_d = ram_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
        2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
        default: count_d = count_q;
      endcase
    end

    // Set beats clear when both happen in one cycle.
    overflow_d  = (write_i && full  && !flush_i) || (overflow_q  && !clear_err_i);
    underflow_d = (read_i  && empty && !flush_i) || (underflow_q && !clear_err_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // In FWFT mode the head word is shown straight from the RAM; it is masked
  // to zero while empty so stale (never-reset) memory is not exposed.
  assign rvalid_o = (FWFT == FIFO_MODE_FWFT) ? !empty : rvalid_q;
  assign rdata_o  = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : ram_rdata) : rdata_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and
// are compared against a queue-based reference model.
module tb_fifo_flags;

  logic       clk = 1'b0;
  logic       rst, wr, rd, fl, ce;
  logic [7:0] wd;

  logic [7:0] s_rdata, f_rdata;
  logic       s_rvalid, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic       f_rvalid, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  always #5 clk = ~clk;

  fifo_flags #(.WORD_BITS(8), .ADDR_BITS(4), .FWFT(0)) dut_std (
    .clk_i(clk), .reset_i(rst), .write_i(wr), .wdata_i(wd), .read_i(rd),
    .flush_i(fl), .clear_err_i(ce), .rdata_o(s_rdata), .rvalid_o(s_rvalid),
    .empty_o(s_empty), .full_o(s_full), .almost_empty_o(s_ae),
    .almost_full_o(s_af), .count_o(s_count), .overflow_o(s_ovf),
    .underflow_o(s_udf)
  );

  fifo_flags #(.WORD_BITS(8), .ADDR_BITS(4), .FWFT(1)) dut_fw (
    .clk_i(clk), .reset_i(rst), .write_i(wr), .wdata_i(wd), .read_i(rd),
    .flush_i(fl), .clear_err_i(ce), .rdata_o(f_rdata), .rvalid_o(f_rvalid),
    .empty_o(f_empty), .full_o(f_full), .almost_empty_o(f_ae),
    .almost_full_o(f_af), .count_o(f_count), .overflow_o(f_ovf),
    .underflow_o(f_udf)
  );

  wire [10:0] s_stat = {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf};
  wire [10:0] f_stat = {f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf};

  int checks = 0;
  int passed = 0;

  // Reference model: contents as a queue plus the error/read-data state.
  logic [7:0] mq[$];
  logic       ovf_m, udf_m, rv_m;
  logic [7:0] rd_m;

  function automatic logic [10:0] exp_stat();
    int sz;
    sz = mq.size();
    return {5'(sz), sz == 0, sz == 16, sz <= 2, sz >= 14, ovf_m, udf_m};
  endfunction

  function automatic logic [8:0] exp_fw();
    if (mq.size() != 0) return {1'b1, mq[0]};
    return 9'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    ovf_m = 1'b0; udf_m = 1'b0; rv_m = 1'b0; rd_m = 8'd0;
  endtask

  // Drive one cycle of requests, advance the model across the edge, sample at +1.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    bit was_full, was_empty;
    wr = w; wd = d; rd = r; fl = f; ce = c;
    @(posedge clk);
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    ovf_m = (w && was_full  && !f) || (ovf_m && !c);
    udf_m = (r && was_empty && !f) || (udf_m && !c);
    if (f) begin
      mq.delete();
      rv_m = 1'b0;
    end else begin
      rv_m = r && !was_empty;
      if (rv_m) rd_m = mq.pop_front();
      if (w && !was_full) mq.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0; fl = 1'b0; ce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 0; rd = 0; fl = 0; ce = 0; wd = 8'd0;
    model_reset();
    #12;
    checks++; if (s_stat !== 11'b00000_1_0_1_0_0_0) $display("FAIL reset_std_stat got=%b exp=%b", s_stat, 11'b00000_1_0_1_0_0_0); else passed++;
    checks++; if (f_stat !== 11'b00000_1_0_1_0_0_0) $display("FAIL reset_fw_stat got=%b exp=%b", f_stat, 11'b00000_1_0_1_0_0_0); else passed++;
    checks++; if ({s_rvalid, s_rdata} !== 9'd0) $display("FAIL reset_std_rd got=%h exp=0", {s_rvalid, s_rdata}); else passed++;
    checks++; if ({f_rvalid, f_rdata} !== 9'd0) $display("FAIL reset_fw_rd got=%h exp=0", {f_rvalid, f_rdata}); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks++; if (s_stat !== exp_stat()) $display("FAIL fill_stat[%0d] got=%b exp=%b", i, s_stat, exp_stat()); else passed++;
      checks++; if (s_af !== (i >= 14)) $display("FAIL fill_afull[%0d] got=%b exp=%b", i, s_af, (i >= 14)); else passed++;
      checks++; if ({f_rvalid, f_rdata} !== {1'b1, 8'd1}) $display("FAIL fill_fw_head[%0d] got=%h exp=101", i, {f_rvalid, f_rdata}); else passed++;
    end
    checks++; if ({s_full, s_count} !== {1'b1, 5'd16}) $display("FAIL fill_full got=%b/%0d exp=1/16", s_full, s_count); else passed++;
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_ovf, s_count} !== {1'b1, 5'd16}) $display("FAIL fill_overflow got=%b/%0d exp=1/16", s_ovf, s_count); else passed++;
    checks++; if (f_stat !== exp_stat()) $display("FAIL fill_fw_stat got=%b exp=%b", f_stat, exp_stat()); else passed++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      checks++; if ({s_rvalid, s_rdata} !== {1'b1, 8'(i)}) $display("FAIL drain_data[%0d] got=%h exp=%h", i, {s_rvalid, s_rdata}, {1'b1, 8'(i)}); else passed++;
      checks++; if (s_stat !== exp_stat()) $display("FAIL drain_stat[%0d] got=%b exp=%b", i, s_stat, exp_stat()); else passed++;
      checks++; if ({f_rvalid, f_rdata} !== exp_fw()) $display("FAIL drain_fw[%0d] got=%h exp=%h", i, {f_rvalid, f_rdata}, exp_fw()); else passed++;
    end
    checks++; if (s_empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", s_empty); else passed++;
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_rvalid, s_rdata} !== {1'b0, 8'd16}) $display("FAIL drain_pulse got=%h exp=010", {s_rvalid, s_rdata}); else passed++;
    cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if ({s_udf, s_rvalid} !== 2'b10) $display("FAIL drain_underflow got=%b exp=10", {s_udf, s_rvalid}); else passed++;
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checks++; if ({s_ovf, s_udf} !== 2'b00) $display("FAIL clear_err got=%b exp=00", {s_ovf, s_udf}); else passed++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      checks++; if (s_count !== 5'd8) $display("FAIL stream_count[%0d] got=%0d exp=8", i, s_count); else passed++;
      checks++; if ({s_rvalid, s_rdata} !== {1'b1, rd_m}) $display("FAIL stream_data[%0d] got=%h exp=%h", i, {s_rvalid, s_rdata}, {1'b1, rd_m}); else passed++;
      checks++; if ({f_rvalid, f_rdata} !== exp_fw()) $display("FAIL stream_fw[%0d] got=%h exp=%h", i, {f_rvalid, f_rdata}, exp_fw()); else passed++;
    end
  endtask

  task automatic test_full_rw();
    while (mq.size() < 16) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    checks++; if ({s_count, s_ovf} !== {5'd15, 1'b1}) $display("FAIL full_rw got=%0d/%b exp=15/1", s_count, s_ovf); else passed++;
    checks++; if ({s_rvalid, s_rdata} !== {1'b1, rd_m}) $display("FAIL full_rw_data got=%h exp=%h", {s_rvalid, s_rdata}, {1'b1, rd_m}); else passed++;
  endtask

  task automatic test_fwft();
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++; if ({f_rvalid, f_rdata} !== {1'b1, 8'hA5}) $display("FAIL fwft_head got=%h exp=1a5", {f_rvalid, f_rdata}); else passed++;
    cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if ({f_empty, f_rvalid} !== 2'b10) $display("FAIL fwft_pop got=%b exp=10", {f_empty, f_rvalid}); else passed++;
  endtask

  task automatic test_flush();
    logic ovf_before;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    ovf_before = ovf_m;
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checks++; if ({s_count, s_empty, s_ovf} !== {5'd0, 1'b1, ovf_before}) $display("FAIL flush got=%0d/%b/%b exp=0/1/%b", s_count, s_empty, s_ovf, ovf_before); else passed++;
    checks++; if (f_stat !== exp_stat()) $display("FAIL flush_fw_stat got=%b exp=%b", f_stat, exp_stat()); else passed++;
    cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if ({s_ovf, s_udf} !== {ovf_m, 1'b1}) $display("FAIL flush_udf got=%b exp=%b", {s_ovf, s_udf}, {ovf_m, 1'b1}); else passed++;
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checks++; if ({s_ovf, s_udf, f_ovf, f_udf} !== 4'b0000) $display("FAIL flush_clear got=%b exp=0000", {s_ovf, s_udf, f_ovf, f_udf}); else passed++;
  endtask

  task automatic test_random();
    int pw;
    for (int i = 0; i < 400; i++) begin
      pw = ((i / 50) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      checks++; if (s_stat !== exp_stat()) $display("FAIL rand_std_stat[%0d] got=%b exp=%b", i, s_stat, exp_stat()); else passed++;
      checks++; if (f_stat !== exp_stat()) $display("FAIL rand_fw_stat[%0d] got=%b exp=%b", i, f_stat, exp_stat()); else passed++;
      checks++; if ({s_rvalid, s_rdata} !== {rv_m, rd_m}) $display("FAIL rand_std_data[%0d] got=%h exp=%h", i, {s_rvalid, s_rdata}, {rv_m, rd_m}); else passed++;
      checks++; if ({f_rvalid, f_rdata} !== exp_fw()) $display("FAIL rand_fw_data[%0d] got=%h exp=%h", i, {f_rvalid, f_rdata}, exp_fw()); else passed++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), i[0], 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    wr = 1'b1; wd = 8'h5A;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (s_stat !== 11'b00000_1_0_1_0_0_0) $display("FAIL areset_std_stat got=%b exp=%b", s_stat, 11'b00000_1_0_1_0_0_0); else passed++;
    checks++; if (f_stat !== 11'b00000_1_0_1_0_0_0) $display("FAIL areset_fw_stat got=%b exp=%b", f_stat, 11'b00000_1_0_1_0_0_0); else passed++;
    checks++; if ({s_rvalid, s_rdata, f_rvalid, f_rdata} !== 18'd0) $display("FAIL areset_rd got=%h exp=0", {s_rvalid, s_rdata, f_rvalid, f_rdata}); else passed++;
    #3;
    rst = 1'b0;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    checks++; if ({s_count, f_rvalid, f_rdata} !== {5'd1, 1'b1, 8'h5A}) $display("FAIL areset_first_write got=%0d/%h exp=1/15a", s_count, {f_rvalid, f_rdata}); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_rw();
    test_fwft();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
